fp_div_operand_unpacker: RTL
============================

Name: fp_div_operand_unpacker

Overview:
- Front-end stage of the single-precision FP divider.
- Accepts a dividend/divisor pair over a valid/ready handshake and classifies each operand as NaN, zero, Inf, normal or subnormal.
- Unpacks each operand into an unbiased exponent and a 24-bit mantissa; subnormals are normalised over multiple cycles.
- Emits the a_/b_ class flags and res_sign consumed by the divider's special-case handler, plus operands ready for the mantissa datapath.

Parameters:
- EXP_W, 10: width of the signed unbiased exponent outputs. Must be ≥ 9; covers -149..+127.
- NORM_STEP, 1: maximum left-shift applied per cycle during normalisation. Legal values are 1, 2 and 4.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept a pair
- a  in  32  dividend, IEEE-754 single
- b  in  32  divisor, IEEE-754 single
- out_valid  out  1  unpacked result valid
- out_ready  in  1  downstream accepts result
- a_nan, b_nan  out  1 each  operand is NaN (exp=FF, frac≠0)
- a_inf, b_inf  out  1 each  operand is ±Inf (exp=FF, frac=0)
- a_zero, b_zero  out  1 each  operand is ±0 (exp=0, frac=0)
- res_sign  out  1  a[31] XOR b[31]
- a_exp, b_exp  out  EXP_W  signed unbiased exponent
- a_mant, b_mant  out  24  mantissa with explicit leading bit
- busy  out  1  state ≠ IDLE

Behaviour:
- FSM states are IDLE, NORM and OUT.
- in_ready = (state==IDLE). busy = !in_ready.
- Reset (rst_n low, async):
  - state goes to IDLE.
  - out_valid and all flags go to 0; res_sign goes to 0.
  - a_exp, b_exp, a_mant and b_mant go to 0.
  - in_ready reads 1 while in reset.
- Reset asserted mid-operation abandons the pair; out_valid falls immediately with no partial result.
- IDLE: on in_valid && in_ready, register both operands with the following per-operand rules.
  - Normal (exp field 1..FE): exp = E-127, mant = {1, frac}.
  - Subnormal (exp field 0, frac≠0): exp = -126, mant = {0, frac}; the operand is marked pending.
  - Zero, Inf or NaN: the corresponding flag is set, exp = 0, mant = 0, and the operand is never pending.
  - res_sign = a[31]^b[31].
  - Next state is NORM if either operand is pending, else OUT.
- NORM:
  - Each cycle, each pending operand shifts mant left by min(NORM_STEP, leading zeros of mant) and decrements exp by the same amount.
  - An operand clears pending when mant[23]==1.
  - Both operands normalise in parallel. Move to OUT in the cycle after neither operand is pending.
  - Worst case for frac=0x000001 with NORM_STEP=1 is 23 NORM cycles, ending at exp = -149.
- OUT:
  - out_valid=1, and all outputs are held stable while out_ready=0.
  - On out_ready, the transfer completes, out_valid drops next cycle and the FSM returns to IDLE.
  - No new pair is accepted in the same cycle as the OUT handshake.
- Latency from the accept edge to out_valid:
  - No subnormal operand: 1 cycle.
  - With a subnormal operand: 1 + N cycles, where N is the number of NORM cycles.
  - Minimum handshake-to-handshake period is 2 cycles, plus NORM cycles.
- Flags are mutually exclusive per operand.
- Both a_nan and a_zero are never set for the same operand.
- Signed exponent arithmetic is two's complement in EXP_W bits; no overflow is possible within the legal range.
- in_valid while busy is ignored; the pair is not consumed because in_ready=0.

Decomposition:
- Shared header fp_div_defs.vh:
  - EXP_BIAS=127, EXP_SPECIAL=8'hFF, SUBN_EXP=-126, MANT_W=24.
  - FSM state encodings.
- Sub-module fp_operand_classify: combinational, instantiated twice.
  - Input: a 32-bit word.
  - Outputs: nan, inf, zero, subnormal, initial exp and initial mant.
- The unpacker owns the FSM, the registers and the normalisation shifter.

Test Plan:
1. a=0x40400000 (3.0), b=0x3F800000 (1.0) -> out_valid 1 cycle after accept; a_exp=1, a_mant=0xC00000, b_exp=0, b_mant=0x800000, all flags 0, res_sign=0.
2. a=0x7FC00000 (NaN), b=0x80000000 (-0) -> a_nan=1, b_zero=1, res_sign=1, no NORM cycles, a_mant=b_mant=0.
3. a=0x00000001, b=0x3F800000, NORM_STEP=1 -> 23 NORM cycles; a_exp=-149 (0x36B in 10 bits), a_mant=0x800000; out_valid at accept+24.
4. a=0x00400000, b=0x00000003 -> both operands normalise in parallel; a_exp=-127 with a_mant=0x800000; b_exp=-148 with b_mant=0xC00000; total NORM cycles=22.
5. Any result with out_ready held 0 for 5 cycles -> outputs stable, in_ready=0, in_valid pulses ignored; accepted exactly once when out_ready rises.
6. rst_n pulled low during NORM (case 3, cycle 10) -> out_valid=0 and outputs 0 immediately; after release, in_ready=1 and a new pair (0x7F800000, 0x7F800000) gives a_inf=b_inf=1.

Source files
------------

// File: rtl/fp_div_operand_unpacker_pkg.sv
// Shared constants, FSM state type and helpers for the FP divider operand front end.
package fp_div_operand_unpacker_pkg;

    localparam int         EXP_BIAS    = 127;
    localparam logic [7:0] EXP_SPECIAL = 8'hFF;
    localparam int         SUBN_EXP    = -126;
    localparam int         MANT_W      = 24;

    typedef enum logic [1:0] {
        StateIdle = 2'd0,
        StateNorm = 2'd1,
        StateOut  = 2'd2
    } state_e;

    // A mantissa still needs normalising when it is non-zero but lacks its leading one.
    function automatic logic isPending(input logic [MANT_W-1:0] mant);
        return (mant != '0) && !mant[MANT_W-1];
    endfunction

endpackage

// File: rtl/fp_div_operand_unpacker_classify.sv
// Combinational classifier: splits one IEEE-754 single into class flags,
// an initial unbiased exponent and an initial 24-bit mantissa.
module fp_operand_classify
    import fp_div_operand_unpacker_pkg::*;
#(
    parameter int EXP_W = 10
) (
    input  logic [31:0]       word_i,
    output logic              sign_o,
    output logic              nan_o,
    output logic              inf_o,
    output logic              zero_o,
    output logic              subnormal_o,
    output logic [EXP_W-1:0]  exp_o,
    output logic [MANT_W-1:0] mant_o
);

    logic [7:0]  expField;
    logic [22:0] frac;
    logic        fracZero;

    assign sign_o   = word_i[31];
    assign expField = word_i[30:23];
    assign frac     = word_i[22:0];
    assign fracZero = (frac == 23'd0);

    // Decode the class; specials carry a zero exponent and mantissa so they never normalise.
    always_comb begin
        nan_o       = 1'b0;
        inf_o       = 1'b0;
        zero_o      = 1'b0;
        subnormal_o = 1'b0;
        exp_o       = '0;
        mant_o      = '0;
        if (expField == EXP_SPECIAL) begin
            nan_o = !fracZero;
            inf_o = fracZero;
        end else if (expField == 8'd0) begin
            if (fracZero) begin
                zero_o = 1'b1;
            end else begin
                subnormal_o = 1'b1;
                exp_o       = EXP_W'(SUBN_EXP);
                mant_o      = {1'b0, frac};
            end
        end else begin
            exp_o  = EXP_W'({1'b0, expField}) - EXP_W'(EXP_BIAS);
            mant_o = {1'b1, frac};
        end
    end

endmodule

// File: rtl/fp_div_operand_unpacker.sv
// Front end of the single-precision divider: accepts an operand pair, classifies
// both, normalises subnormals a few bits per cycle and presents the unpacked result.
module fp_div_operand_unpacker
    import fp_div_operand_unpacker_pkg::*;
#(
    parameter int EXP_W     = 10,
    parameter int NORM_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       a,
    input  logic [31:0]       b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              a_nan,
    output logic              b_nan,
    output logic              a_inf,
    output logic              b_inf,
    output logic              a_zero,
    output logic              b_zero,
    output logic              res_sign,
    output logic [EXP_W-1:0]  a_exp,
    output logic [EXP_W-1:0]  b_exp,
    output logic [MANT_W-1:0] a_mant,
    output logic [MANT_W-1:0] b_mant,
    output logic              busy
);

    state_e              state_q;
    logic                outValid_q;
    logic                aNan_q, aInf_q, aZero_q;
    logic                bNan_q, bInf_q, bZero_q;
    logic                resSign_q;
    logic [EXP_W-1:0]    aExp_q, bExp_q, aExp_d, bExp_d;
    logic [MANT_W-1:0]   aMant_q, bMant_q, aMant_d, bMant_d;

    logic                aSign, aNanC, aInfC, aZeroC, aSubC;
    logic                bSign, bNanC, bInfC, bZeroC, bSubC;
    logic [EXP_W-1:0]    aExpC, bExpC;
    logic [MANT_W-1:0]   aMantC, bMantC;

    fp_operand_classify #(.EXP_W(EXP_W)) uClassA (
        .word_i      (a),
        .sign_o      (aSign),
        .nan_o       (aNanC),
        .inf_o       (aInfC),
        .zero_o      (aZeroC),
        .subnormal_o (aSubC),
        .exp_o       (aExpC),
        .mant_o      (aMantC)
    );

    fp_operand_classify #(.EXP_W(EXP_W)) uClassB (
        .word_i      (b),
        .sign_o      (bSign),
        .nan_o       (bNanC),
        .inf_o       (bInfC),
        .zero_o      (bZeroC),
        .subnormal_o (bSubC),
        .exp_o       (bExpC),
        .mant_o      (bMantC)
    );

    // One normalisation step: shift each pending mantissa by up to NORM_STEP bits, stopping at the leading one.
    always_comb begin
        aMant_d = aMant_q;
        aExp_d  = aExp_q;
        bMant_d = bMant_q;
        bExp_d  = bExp_q;
        for (int i = 0; i < NORM_STEP; i++) begin
            if (isPending(aMant_d)) begin
                aMant_d = aMant_d << 1;
                aExp_d  = aExp_d - EXP_W'(1);
            end
            if (isPending(bMant_d)) begin
                bMant_d = bMant_d << 1;
                bExp_d  = bExp_d - EXP_W'(1);
            end
        end
    end

    // Control FSM and all result registers; reset abandons any pair in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StateIdle;
            outValid_q <= 1'b0;
            aNan_q     <= 1'b0;
            aInf_q     <= 1'b0;
            aZero_q    <= 1'b0;
            bNan_q     <= 1'b0;
            bInf_q     <= 1'b0;
            bZero_q    <= 1'b0;
            resSign_q  <= 1'b0;
            aExp_q     <= '0;
            bExp_q     <= '0;
            aMant_q    <= '0;
            bMant_q    <= '0;
        end else begin
            case (state_q)
                StateIdle: begin
                    if (in_valid) begin
                        aNan_q     <= aNanC;
                        aInf_q     <= aInfC;
                        aZero_q    <= aZeroC;
                        bNan_q     <= bNanC;
                        bInf_q     <= bInfC;
                        bZero_q    <= bZeroC;
                        resSign_q  <= aSign ^ bSign;
                        aExp_q     <= aExpC;
                        bExp_q     <= bExpC;
                        aMant_q    <= aMantC;
                        bMant_q    <= bMantC;
                        if (aSubC || bSubC) begin
                            state_q <= StateNorm;
                        end else begin
                            state_q    <= StateOut;
                            outValid_q <= 1'b1;
                        end
                    end
                end
                StateNorm: begin
                    aExp_q  <= aExp_d;
                    bExp_q  <= bExp_d;
                    aMant_q <= aMant_d;
                    bMant_q <= bMant_d;
                    if (!isPending(aMant_d) && !isPending(bMant_d)) begin
                        state_q    <= StateOut;
                        outValid_q <= 1'b1;
                    end
                end
                StateOut: begin
                    if (out_ready) begin
                        state_q    <= StateIdle;
                        outValid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StateIdle;
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == StateIdle);
    assign busy      = !in_ready;
    assign out_valid = outValid_q;
    assign a_nan     = aNan_q;
    assign a_inf     = aInf_q;
    assign a_zero    = aZero_q;
    assign b_nan     = bNan_q;
    assign b_inf     = bInf_q;
    assign b_zero    = bZero_q;
    assign res_sign  = resSign_q;
    assign a_exp     = aExp_q;
    assign b_exp     = bExp_q;
    assign a_mant    = aMant_q;
    assign b_mant    = bMant_q;

endmodule
